// File: rtl/lbp_stream_engine_if.sv
// Gray-ROM read port and LBP-RAM write port of the LBP stream engine.
// master = engine side, slave = memory/testbed side.
interface lbp_stream_engine_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] gray_addr;
    logic              gray_req;
    logic              gray_ready;
    logic [DATA_W-1:0] gray_data;
    logic [ADDR_W-1:0] lbp_addr;
    logic              lbp_valid;
    logic [7:0]        lbp_data;
    logic              finish;

    modport master (
        output gray_addr, gray_req,
        input  gray_ready, gray_data,
        output lbp_addr, lbp_valid, lbp_data, finish
    );

    modport slave (
        input  gray_addr, gray_req,
        output gray_ready, gray_data,
        input  lbp_addr, lbp_valid, lbp_data, finish
    );
endinterface

// File: rtl/lbp_stream_engine.sv
// Streaming 3x3 LBP engine: one raster read per pixel, two line buffers, one code per interior pixel.
// Optional LBP_BORDER_EN: after the interior codes, write 0 to every border address in raster order.
module lbp_stream_engine #(
    parameter int IMG_W  = 128,
    parameter int IMG_H  = 128,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 14
) (
    input  logic                 clk,
    input  logic                 reset,
    lbp_stream_engine_if.master  bus
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(IMG_W);
    localparam int RW   = $clog2(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(NPIX - 1);
    localparam logic [ADDR_W-1:0] ROW_OFS = ADDR_W'(IMG_W + 1);
    localparam logic [CW-1:0]     LAST_C  = CW'(IMG_W - 1);
    localparam logic [RW-1:0]     LAST_R  = RW'(IMG_H - 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] DRAIN  = 3'd2;
    localparam logic [2:0] BORDER = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    function automatic logic [7:0] lbp_code(
        input logic [DATA_W-1:0] ctr,
        input logic [DATA_W-1:0] n0, n1, n2, n3, n4, n5, n6, n7
    );
        return {n7 >= ctr, n6 >= ctr, n5 >= ctr, n4 >= ctr,
                n3 >= ctr, n2 >= ctr, n1 >= ctr, n0 >= ctr};
    endfunction

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] gaddr_q;
    logic [ADDR_W-1:0] in_idx_q;
    logic              pend_q;
    logic [CW-1:0]     col_q;
    logic [RW-1:0]     row_q;
    logic [DATA_W-1:0] lb0_q [IMG_W];
    logic [DATA_W-1:0] lb1_q [IMG_W];
    logic [DATA_W-1:0] win_q [3][2];
    logic              lbp_valid_q, finish_q;
    logic [ADDR_W-1:0] lbp_addr_q;
    logic [7:0]        lbp_data_q;

    logic              req, emit, last_px;
    logic [DATA_W-1:0] top, mid, pix;
    logic [7:0]        code;

    assign req     = (state_q == FETCH) && bus.gray_ready;
    assign pix     = bus.gray_data;
    assign top     = lb0_q[col_q];
    assign mid     = lb1_q[col_q];
    assign last_px = pend_q && (in_idx_q == LAST_A);
    // Columns 0/1 of a row would pair the window with the previous row's tail.
    assign emit    = pend_q && (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign code    = lbp_code(win_q[1][1], win_q[0][0], win_q[0][1], top,
                              win_q[1][0], mid, win_q[2][0], win_q[2][1], pix);

    assign bus.gray_addr = gaddr_q;
    assign bus.gray_req  = req;
    assign bus.lbp_addr  = lbp_addr_q;
    assign bus.lbp_valid = lbp_valid_q;
    assign bus.lbp_data  = lbp_data_q;
    assign bus.finish    = finish_q;

`ifdef LBP_BORDER_EN
    logic [ADDR_W-1:0] baddr_q;
    logic [CW-1:0]     bcol_q;
    logic [RW-1:0]     brow_q;
    logic              bedge;

    assign bedge = (brow_q == '0) || (brow_q == LAST_R);
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.gray_ready) state_d = FETCH;
            FETCH:   if (req && gaddr_q == LAST_A) state_d = DRAIN;
`ifdef LBP_BORDER_EN
            DRAIN:   if (last_px) state_d = BORDER;
            BORDER:  if (baddr_q == LAST_A) state_d = DONE;
`else
            DRAIN:   if (last_px) state_d = DONE;
`endif
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            gaddr_q  <= '0;
            pend_q   <= 1'b0;
            in_idx_q <= '0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= req;
            if (req && gaddr_q != LAST_A) gaddr_q <= gaddr_q + 1'b1;
            // Position tracks the pixel arriving this cycle; it parks on the last pixel.
            if (pend_q && !last_px) begin
                in_idx_q <= in_idx_q + 1'b1;
                if (col_q == LAST_C) begin
                    col_q <= '0;
                    row_q <= row_q + 1'b1;
                end else begin
                    col_q <= col_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < IMG_W; i++) begin
                lb0_q[i] <= '0;
                lb1_q[i] <= '0;
            end
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= '0;
                win_q[r][1] <= '0;
            end
        end else if (pend_q) begin
            lb0_q[col_q] <= mid;
            lb1_q[col_q] <= pix;
            win_q[0][0]  <= win_q[0][1];
            win_q[0][1]  <= top;
            win_q[1][0]  <= win_q[1][1];
            win_q[1][1]  <= mid;
            win_q[2][0]  <= win_q[2][1];
            win_q[2][1]  <= pix;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lbp_valid_q <= 1'b0;
            lbp_addr_q  <= '0;
            lbp_data_q  <= '0;
            finish_q    <= 1'b0;
        end else begin
            lbp_valid_q <= 1'b0;
            finish_q    <= (state_q == DONE);
            if (emit) begin
                lbp_valid_q <= 1'b1;
                lbp_addr_q  <= in_idx_q - ROW_OFS;
                lbp_data_q  <= code;
            end
`ifdef LBP_BORDER_EN
            if (state_q == BORDER) begin
                lbp_valid_q <= 1'b1;
                lbp_addr_q  <= baddr_q;
                lbp_data_q  <= '0;
            end
`endif
        end
    end

`ifdef LBP_BORDER_EN
    // Walk border pixels only: middle rows jump from column 0 straight to column IMG_W-1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baddr_q <= '0;
            bcol_q  <= '0;
            brow_q  <= '0;
        end else if (state_q == BORDER && baddr_q != LAST_A) begin
            if (bcol_q == LAST_C) begin
                bcol_q  <= '0;
                brow_q  <= brow_q + 1'b1;
                baddr_q <= baddr_q + 1'b1;
            end else if (bedge) begin
                bcol_q  <= bcol_q + 1'b1;
                baddr_q <= baddr_q + 1'b1;
            end else begin
                bcol_q  <= LAST_C;
                baddr_q <= baddr_q + ADDR_W'(IMG_W - 1);
            end
        end
    end
`endif
endmodule
